// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the core controller and the iterative mul/div unit.
// The controller drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [RD_W-1:0] rd_in;
  logic            busy;
  logic            done;
  logic            we;
  logic [RD_W-1:0] rd;
  logic [XLEN-1:0] wdata;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, we, rd, wdata
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, we, rd, wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply, restoring divide, one-cycle regfile write.
// Build option MULDIV_EARLY_OUT_EN: trivial/special operands jump straight from IDLE to DONE.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave mdu
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              is_div, a_sgn, b_sgn, div_zero, div_ovf, mul_zero, spec_i;
  logic [XLEN-1:0]   mag_a, mag_b, spec_val_i;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, div_val, div_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    is_div   = mdu.funct3[2];
    a_sgn    = is_div ? (~mdu.funct3[0] & mdu.rs1_val[XLEN-1])
                      : ((mdu.funct3 == 3'b001 || mdu.funct3 == 3'b010) & mdu.rs1_val[XLEN-1]);
    b_sgn    = is_div ? (~mdu.funct3[0] & mdu.rs2_val[XLEN-1])
                      : ((mdu.funct3 == 3'b001) & mdu.rs2_val[XLEN-1]);
    mag_a    = a_sgn ? -mdu.rs1_val : mdu.rs1_val;
    mag_b    = b_sgn ? -mdu.rs2_val : mdu.rs2_val;
    div_zero = is_div && (mdu.rs2_val == '0);
    div_ovf  = is_div && !mdu.funct3[0] && (mdu.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
               && (mdu.rs2_val == '1);
    mul_zero = !is_div && (mdu.rs1_val == '0 || mdu.rs2_val == '0);
    spec_i   = div_zero || div_ovf || mul_zero;
    // Special results bypass the sign fix-up entirely.
    if (div_zero)     spec_val_i = mdu.funct3[1] ? mdu.rs1_val : '1;
    else if (div_ovf) spec_val_i = mdu.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else              spec_val_i = '0;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_sub   = div_shift[XLEN-1:0] - opnd_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    prod       = '0;
    div_val    = '0;
    div_res    = '0;

    case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          f3_d       = mdu.funct3;
          rd_d       = mdu.rd_in;
          neg_d      = (is_div && mdu.funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
          special_d  = spec_i;
          spec_val_d = spec_val_i;
          acc_d      = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          opnd_d     = is_div ? mag_b : mag_a;
          cnt_d      = '0;
          state_d    = is_div ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
          if (spec_i) state_d = S_DONE;
`endif
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DIV: begin
        if (div_shift >= {1'b0, opnd_q}) acc_d = {div_sub, acc_q[XLEN-2:0], 1'b1};
        else                             acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result is captured from the final datapath value on entry to DONE.
    if (state_d == S_DONE && state_q != S_DONE) begin
      prod    = neg_d ? -acc_d : acc_d;
      div_val = f3_d[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      div_res = neg_d ? -div_val : div_val;
      if (special_d)         wdata_d = spec_val_d;
      else if (f3_d[2])      wdata_d = div_res;
      else if (f3_d == 3'b0) wdata_d = prod[XLEN-1:0];
      else                   wdata_d = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      f3_q       <= f3_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mdu.busy  = (state_q != S_IDLE);
  assign mdu.done  = (state_q == S_DONE);
  assign mdu.we    = (state_q == S_DONE) && (rd_q != '0);
  assign mdu.rd    = rd_q;
  assign mdu.wdata = wdata_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus handshake and mid-op reset sequences.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32), .RD_W(5)) bus ();
  muldiv_unit #(.XLEN(32), .RD_W(5)) dut (.clk(clk), .reset(reset), .mdu(bus));

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    logic [31:0] wd;
    logic        we_s;
    logic [4:0]  rd_s;
    lat = 0; wd = '0; we_s = 1'b0; rd_s = '0;
    issue(v.f3, v.a, v.b, v.rd);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check({name, " busy"}, {31'b0, bus.busy}, 32'd1);
      if (bus.done) begin
        lat = k; wd = bus.wdata; we_s = bus.we; rd_s = bus.rd;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 40 cycles, expected one", name);
    end else begin
      check({name, " latency"}, lat, (v.early && EARLY) ? 32'd1 : 32'd33);
      check({name, " wdata"}, wd, v.exp);
      check({name, " we"}, {31'b0, we_s}, {31'b0, (v.rd != 5'd0)});
      check({name, " rd"}, {27'b0, rd_s}, {27'b0, v.rd});
      @(negedge clk);
      check({name, " done pulse"}, {31'b0, bus.done}, 32'd0);
      check({name, " wdata hold"}, bus.wdata, v.exp);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, dlat;
    logic [31:0] dwd;

    vecs.push_back(vec_t'{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0});
    vecs.push_back(vec_t'{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0});
    vecs.push_back(vec_t'{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0});
    vecs.push_back(vec_t'{3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0});
    vecs.push_back(vec_t'{3'b001, 32'hFFFFFFFD, 32'd7,        5'd9,  32'hFFFFFFFF, 1'b0});
    vecs.push_back(vec_t'{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b0});
    vecs.push_back(vec_t'{3'b100, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 1'b0});
    vecs.push_back(vec_t'{3'b110, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 1'b0});
    vecs.push_back(vec_t'{3'b101, 32'd100,      32'd7,        5'd13, 32'd14,       1'b0});
    vecs.push_back(vec_t'{3'b111, 32'd100,      32'd7,        5'd14, 32'd2,        1'b0});
    vecs.push_back(vec_t'{3'b100, 32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 1'b0});
    vecs.push_back(vec_t'{3'b110, 32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        1'b0});
    vecs.push_back(vec_t'{3'b100, 32'h1234,     32'd0,        5'd17, 32'hFFFFFFFF, 1'b1});
    vecs.push_back(vec_t'{3'b101, 32'h1234,     32'd0,        5'd18, 32'hFFFFFFFF, 1'b1});
    vecs.push_back(vec_t'{3'b110, 32'h1234,     32'd0,        5'd19, 32'h1234,     1'b1});
    vecs.push_back(vec_t'{3'b111, 32'h1234,     32'd0,        5'd20, 32'h1234,     1'b1});
    vecs.push_back(vec_t'{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1'b1});
    vecs.push_back(vec_t'{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        1'b1});
    vecs.push_back(vec_t'{3'b000, 32'd0,        32'd5,        5'd23, 32'd0,        1'b1});
    vecs.push_back(vec_t'{3'b001, 32'h12345678, 32'd0,        5'd24, 32'd0,        1'b1});
    vecs.push_back(vec_t'{3'b000, 32'd6,        32'd9,        5'd0,  32'd54,       1'b0});

    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset busy",  {31'b0, bus.busy}, 32'd0);
    check("reset done",  {31'b0, bus.done}, 32'd0);
    check("reset we",    {31'b0, bus.we},   32'd0);
    check("reset rd",    {27'b0, bus.rd},   32'd0);
    check("reset wdata", bus.wdata,         32'd0);

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start held high during cycles T+5..T+20 with different operands must be ignored.
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3);
    ndone = 0; dlat = 0; dwd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; dlat = k; dwd = bus.wdata; end
      if (k >= 4 && k < 20) begin
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_val = 32'd3;
        bus.rs2_val = 32'd3; bus.rd_in = 5'd4;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ignore done count", ndone, 32'd1);
    check("ignore latency",    dlat,  32'd33);
    check("ignore wdata",      dwd,   32'hFFFFFFEB);

    // Asynchronous reset in the middle of an operation.
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort busy",  {31'b0, bus.busy}, 32'd0);
    check("abort done",  {31'b0, bus.done}, 32'd0);
    check("abort we",    {31'b0, bus.we},   32'd0);
    check("abort rd",    {27'b0, bus.rd},   32'd0);
    check("abort wdata", bus.wdata,         32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort no done", ndone, 32'd0);
    run_vec("post reset", vec_t'{3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
